// File: rtl/mult_pkg.sv
// mult_pkg: shared constants, FSM state type and digit/step helpers for mult_nibble_seq
package mult_pkg;
  localparam int NIB = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int steps(input int opw);
    return (opw / NIB) * (opw / NIB);
  endfunction
  function automatic int dig_i(input int k, input int d);
    return k % d;
  endfunction
  function automatic int dig_j(input int k, input int d);
    return k / d;
  endfunction
endpackage

// File: rtl/mult_nibble_seq_simplewallace.sv
// simplewallace: combinational 4x4 unsigned multiplier (a, b in -> p = a*b, 8 bits)
module simplewallace (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] row [4];
  logic [7:0] s, c;
  for (genvar n = 0; n < 4; n++) begin : g_row
    assign row[n] = {4'b0, a & {4{b[n]}}} << n;
  end
  assign s = row[0] ^ row[1] ^ row[2];
  assign c = ((row[0] & row[1]) | (row[0] & row[2]) | (row[1] & row[2])) << 1;
  assign p = s + c + row[3];
endmodule

// File: rtl/mult_nibble_seq.sv
// mult_nibble_seq: sequential OPWxOPW multiplier; ports clk, rst, in_valid/in_ready/a/b in, out_valid/out_ready/p out, busy; MULT_EARLY_ZERO_EN sends zero operands straight to DONE
module mult_nibble_seq
  import mult_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] p,
  output logic             busy
);
  localparam int D = OPW / NIB;
  localparam int S = steps(OPW);
  localparam int KW = $clog2(S);
  state_t state;
  logic [KW-1:0] k;
  logic [OPW-1:0] a_r, b_r;
  logic [2*OPW-1:0] acc, term;
  logic [NIB-1:0] na, nb;
  logic [2*NIB-1:0] prod;
  logic zero;
`ifdef MULT_EARLY_ZERO_EN
  assign zero = (a == '0) || (b == '0);
`else
  assign zero = 1'b0;
`endif
  always_comb begin
    na = a_r[NIB*dig_i(int'(k), D) +: NIB];
    nb = b_r[NIB*dig_j(int'(k), D) +: NIB];
    term = {{(2*OPW-2*NIB){1'b0}}, prod} << (NIB * (dig_i(int'(k), D) + dig_j(int'(k), D)));
  end
  simplewallace u_mul (.a(na), .b(nb), .p(prod));
  assign p = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      acc <= '0;
      k <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          acc <= '0;
          k <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          out_valid <= zero;
          state <= zero ? DONE : CALC;
        end
        CALC: begin
          acc <= acc + term;
          k <= k + 1'b1;
          if (k == KW'(S - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_nibble_seq.sv
// tb_mult_nibble_seq: scoreboard bench for mult_nibble_seq against an a*b reference model
module tb_mult_nibble_seq;
  localparam int OPW = 8;
  localparam int S = (OPW / 4) * (OPW / 4);
`ifdef MULT_EARLY_ZERO_EN
  localparam int LATZ = 1;
`else
  localparam int LATZ = S + 1;
`endif
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [OPW-1:0] a = '0, b = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [2*OPW-1:0] p;
  logic busy;
  logic [2*OPW-1:0] sb [$];
  int errors = 0;
  int checks = 0;
  bit rnd_rdy = 0;
  bit force_rdy = 1;
  bit held = 0;
  logic [2*OPW-1:0] held_p = '0;
  mult_nibble_seq #(.OPW(OPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction
  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_p", 32'(p), 32'(held_p));
        chk("hold_in_ready", 32'(in_ready), 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 32'(p), 32'hdead_beef);
        else chk("product", 32'(p), 32'(sb.pop_front()));
      end
      held = out_valid && !out_ready;
      held_p = p;
    end
  end
  task automatic send(input logic [OPW-1:0] x, input logic [OPW-1:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    else begin
      in_valid = 1;
      a = x;
      b = y;
      sb.push_back({{OPW{1'b0}}, x} * {{OPW{1'b0}}, y});
      @(posedge clk);
      #1;
      in_valid = 0;
      a = OPW'($urandom);
      b = OPW'($urandom);
    end
  endtask
  task automatic measure(input string name, input int lat);
    int first = 0;
    int rdy = 0;
    for (int n = 1; n <= 60 && rdy == 0; n++) begin
      @(negedge clk);
      if (out_valid && first == 0) first = n;
      if (in_ready) begin
        rdy = n;
        chk({name, "_ov_one_cycle"}, 32'(out_valid), 0);
      end
    end
    chk({name, "_latency"}, 32'(first), 32'(lat));
    chk({name, "_in_ready_back"}, 32'(rdy), 32'(lat + 1));
  endtask
  initial begin
    int n;
    logic [OPW-1:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_p", 32'(p), 0);
    rst = 0;
    send(8'hFF, 8'hFF);
    chk("busy_in_calc", 32'(busy), 1);
    measure("ff_ff", S + 1);
    send(8'h12, 8'h34);
    measure("12_34", S + 1);
    force_rdy = 0;
    send(8'hA5, 8'h3C);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 32'(out_valid), 1);
    repeat (10) @(negedge clk);
    chk("bp_p", 32'(p), 32'h26AC);
    force_rdy = 1;
    repeat (3) @(negedge clk);
    send(8'h77, 8'h99);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_p", 32'(p), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 0;
    send(8'hC3, 8'h5E);
    measure("after_rst", S + 1);
    send(8'h00, 8'h5A);
    measure("zero_op", LATZ);
    send(8'h5A, 8'h00);
    measure("zero_op_b", LATZ);
    rnd_rdy = 1;
    for (int i = 0; i < 1200; i++) begin
      x = ($urandom_range(0, 9) == 0) ? '0 : OPW'($urandom);
      y = ($urandom_range(0, 9) == 0) ? '0 : OPW'($urandom);
      if (i % 4 == 0) x = OPW'(i);
      send(x, y);
    end
    rnd_rdy = 0;
    force_rdy = 1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
